// File: rtl/jam_pkg.sv
// Shared definitions for the jam_param assignment search.
// Holds the controller state encoding and the index-width / max-N constants
// used by the top level and the permutation successor block.
package jam_pkg;

  // Width of a worker/job index; fixed so up to MAX_N workers fit.
  localparam int IW    = 3;
  localparam int MAX_N = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    UPDATE = 2'd2,
    DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/jam_next_perm.sv
// Lexicographic successor of a permutation (purely combinational).
//   perm_i    : current permutation, element k at perm_i[k]
//   next_o    : lexicographic successor (don't-care when is_last_o)
//   is_last_o : perm_i is fully descending, i.e. the final permutation
// Classic next-permutation: find the rightmost ascent (pivot), swap the pivot
// with the rightmost larger element, then reverse the suffix after the pivot.
// All element selects are done by comparing against constant loop indices so
// the logic elaborates to plain muxes for any N.
module jam_next_perm
  import jam_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0][IW-1:0] perm_i,
  output logic [N-1:0][IW-1:0] next_o,
  output logic                 is_last_o
);

  int                   piv;
  int                   swi;
  logic [IW-1:0]        pval;
  logic [IW-1:0]        sval;
  logic [N-1:0][IW-1:0] swp;

  always_comb begin
    // Rightmost i with perm[i] < perm[i+1]; -1 means no ascent.
    piv = -1;
    for (int i = 0; i < N-1; i++)
      if (perm_i[i] < perm_i[i+1]) piv = i;
    is_last_o = (piv < 0);

    pval = '0;
    for (int i = 0; i < N; i++)
      if (i == piv) pval = perm_i[i];

    // Suffix after the pivot is descending, so the rightmost element larger
    // than the pivot is the smallest such element.
    swi = 0;
    for (int j = 0; j < N; j++)
      if (j > piv && perm_i[j] > pval) swi = j;

    sval = '0;
    for (int j = 0; j < N; j++)
      if (j == swi) sval = perm_i[j];

    swp = perm_i;
    for (int i = 0; i < N; i++) begin
      if (i == piv) swp[i] = sval;
      if (i == swi) swp[i] = pval;
    end

    // Reverse positions piv+1 .. N-1: element m takes swp[piv+N-m].
    next_o = swp;
    for (int m = 0; m < N; m++)
      if (m > piv)
        for (int s = 0; s < N; s++)
          if (s == piv + N - m) next_o[m] = swp[s];
  end

endmodule

// File: rtl/jam_param.sv
// Exhaustive assignment-problem search over all N! permutations.
// For each permutation the controller walks workers k=0..N-1, drives the
// external cost ROM with (W=k, J=perm[k]), accumulates the returned costs,
// then in one UPDATE cycle scores the total and steps to the next permutation.
// Ports:
//   CLK, RST            : clock, async active-high reset
//   Start, Mode         : launch a search (IDLE only); 0=minimise, 1=maximise
//   W, J, Cost          : cost ROM address (worker, job) and its data
//   MinCost, MatchCount : best total and how many permutations reach it
//   BestPerm            : first best permutation, job of worker k at [3k+2:3k]
//   Valid, Busy         : one-cycle done pulse; high while searching
module jam_param
  import jam_pkg::*;
#(
  parameter int N   = 8,
  parameter int CW  = 7,
  parameter int SW  = 10,
  parameter int MCW = 4
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            Start,
  input  logic            Mode,
  output logic [IW-1:0]   W,
  output logic [IW-1:0]   J,
  input  logic [CW-1:0]   Cost,
  output logic [SW-1:0]   MinCost,
  output logic [MCW-1:0]  MatchCount,
  output logic [IW*N-1:0] BestPerm,
  output logic            Valid,
  output logic            Busy
);

  state_e               state_q, state_d;
  logic                 mode_q;
  logic                 first_q;
  logic [IW-1:0]        k_q;
  logic [SW-1:0]        sum_q;
  logic [N-1:0][IW-1:0] perm_q;
  logic [N-1:0][IW-1:0] best_perm_q;
  logic [SW-1:0]        min_cost_q;
  logic [MCW-1:0]       cnt_q;

  logic [N-1:0][IW-1:0] perm_next;
  logic                 perm_last;
  logic                 better;
  logic                 equal;

  jam_next_perm #(.N(N)) u_next (
    .perm_i    (perm_q),
    .next_o    (perm_next),
    .is_last_o (perm_last)
  );

  assign equal  = (sum_q == min_cost_q);
  assign better = mode_q ? (sum_q > min_cost_q) : (sum_q < min_cost_q);

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (Start) state_d = ACCUM;
      ACCUM:   if (k_q == IW'(N-1)) state_d = UPDATE;
      UPDATE:  state_d = perm_last ? DONE : ACCUM;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs; W/J only carry an address while accumulating.
  always_comb begin
    W     = '0;
    J     = '0;
    Valid = (state_q == DONE);
    Busy  = (state_q == ACCUM) || (state_q == UPDATE);
    if (state_q == ACCUM) begin
      W = k_q;
      for (int i = 0; i < N; i++)
        if (k_q == IW'(i)) J = perm_q[i];
    end
  end

  // Datapath
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mode_q      <= 1'b0;
      first_q     <= 1'b0;
      k_q         <= '0;
      sum_q       <= '0;
      perm_q      <= '0;
      best_perm_q <= '0;
      min_cost_q  <= '0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        IDLE: if (Start) begin
          mode_q  <= Mode;
          first_q <= 1'b1;
          k_q     <= '0;
          sum_q   <= '0;
          for (int i = 0; i < N; i++) perm_q[i] <= IW'(i);
        end
        ACCUM: begin
          sum_q <= sum_q + SW'(Cost);
          k_q   <= k_q + 1'b1;
        end
        UPDATE: begin
          if (first_q || better) begin
            min_cost_q  <= sum_q;
            best_perm_q <= perm_q;
            cnt_q       <= MCW'(1);
          end else if (equal && !(&cnt_q)) begin
            cnt_q <= cnt_q + 1'b1;
          end
          first_q <= 1'b0;
          perm_q  <= perm_next;
          sum_q   <= '0;
          k_q     <= '0;
        end
        default: ;
      endcase
    end
  end

  assign MinCost    = min_cost_q;
  assign MatchCount = cnt_q;
  assign BestPerm   = best_perm_q;

endmodule

// File: tb/tb_jam_param.sv
// Bench for jam_param: three instances (N=3; N=4 with MCW=5; N=4 with MCW=4)
// share clock and reset, each fed by a combinational cost table. Expected
// results are queued when a search is launched and checked on Valid.
module tb_jam_param;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [6:0] cost_fn(input int t, input logic [2:0] w, input logic [2:0] j);
    case (t)
      0:       return 7'(int'(w) * 3 + int'(j));
      1:       return (w == j) ? 7'd9 : 7'd1;
      2:       return 7'(int'(j) * (int'(w) + 1));
      3:       return 7'd127;
      default: return 7'd5;
    endcase
  endfunction

  // Instance a: N=3
  logic s_a = 0, m_a = 0;
  int   t_a = 0;
  logic [2:0] w_a, j_a;
  logic [6:0] c_a;
  logic [9:0] mc_a;
  logic [3:0] cnt_a;
  logic [8:0] pm_a;
  logic v_a, b_a;
  assign c_a = cost_fn(t_a, w_a, j_a);
  jam_param #(.N(3), .CW(7), .SW(10), .MCW(4)) dut_a (
    .CLK(CLK), .RST(RST), .Start(s_a), .Mode(m_a), .W(w_a), .J(j_a), .Cost(c_a),
    .MinCost(mc_a), .MatchCount(cnt_a), .BestPerm(pm_a), .Valid(v_a), .Busy(b_a));

  // Instance b: N=4, MCW=5
  logic s_b = 0, m_b = 0;
  int   t_b = 0;
  logic [2:0] w_b, j_b;
  logic [6:0] c_b;
  logic [9:0] mc_b;
  logic [4:0] cnt_b;
  logic [11:0] pm_b;
  logic v_b, b_b;
  assign c_b = cost_fn(t_b, w_b, j_b);
  jam_param #(.N(4), .CW(7), .SW(10), .MCW(5)) dut_b (
    .CLK(CLK), .RST(RST), .Start(s_b), .Mode(m_b), .W(w_b), .J(j_b), .Cost(c_b),
    .MinCost(mc_b), .MatchCount(cnt_b), .BestPerm(pm_b), .Valid(v_b), .Busy(b_b));

  // Instance c: N=4, MCW=4
  logic s_c = 0, m_c = 0;
  int   t_c = 0;
  logic [2:0] w_c, j_c;
  logic [6:0] c_c;
  logic [9:0] mc_c;
  logic [3:0] cnt_c;
  logic [11:0] pm_c;
  logic v_c, b_c;
  assign c_c = cost_fn(t_c, w_c, j_c);
  jam_param #(.N(4), .CW(7), .SW(10), .MCW(4)) dut_c (
    .CLK(CLK), .RST(RST), .Start(s_c), .Mode(m_c), .W(w_c), .J(j_c), .Cost(c_c),
    .MinCost(mc_c), .MatchCount(cnt_c), .BestPerm(pm_c), .Valid(v_c), .Busy(b_c));

  typedef struct {
    int          mn;
    int          cnt;
    logic [23:0] perm;
    int          s;
    int          lat;
  } sb_t;

  typedef struct {
    logic        md;
    int          t;
    int          mn;
    int          cnt;
    logic [23:0] perm;
  } vec_t;

  sb_t qa[$], qb[$], qc[$];
  sb_t ea, eb, ec;

  task automatic score(input string nm, input sb_t e, input int mn, input int cnt,
                       input logic [23:0] pm);
    chk({nm, "_mincost"}, mn, e.mn);
    chk({nm, "_matchcount"}, cnt, e.cnt);
    chk({nm, "_bestperm"}, pm, e.perm);
    chk({nm, "_latency"}, cyc - e.s, e.lat);
  endtask

  // Scoreboard / protocol monitor, sampled mid-cycle.
  always @(negedge CLK) if (!RST) begin
    if (v_a) begin
      if (qa.size() == 0) chk("a_unexpected_valid", 1, 0);
      else begin ea = qa.pop_front(); score("a", ea, int'(mc_a), int'(cnt_a), 24'(pm_a)); end
    end
    if (v_b) begin
      if (qb.size() == 0) chk("b_unexpected_valid", 1, 0);
      else begin eb = qb.pop_front(); score("b", eb, int'(mc_b), int'(cnt_b), 24'(pm_b)); end
    end
    if (v_c) begin
      if (qc.size() == 0) chk("c_unexpected_valid", 1, 0);
      else begin ec = qc.pop_front(); score("c", ec, int'(mc_c), int'(cnt_c), 24'(pm_c)); end
    end
    chk("a_w_range", (w_a < 3) && (j_a < 3), 1);
    if (!b_a) chk("a_wj_idle", {w_a, j_a}, 0);
  end

  task automatic go(input int d, input logic md, input int t, input int mn, input int cnt,
                    input logic [23:0] pm, input int lat);
    sb_t e;
    @(negedge CLK);
    case (d)
      0:       begin t_a = t; m_a = md; s_a = 1; end
      1:       begin t_b = t; m_b = md; s_b = 1; end
      default: begin t_c = t; m_c = md; s_c = 1; end
    endcase
    @(posedge CLK); #1;
    e = '{mn: mn, cnt: cnt, perm: pm, s: cyc, lat: lat};
    case (d)
      0:       begin s_a = 0; qa.push_back(e); end
      1:       begin s_b = 0; qb.push_back(e); end
      default: begin s_c = 0; qc.push_back(e); end
    endcase
  endtask

  task automatic wait_all(input int bound);
    int i = 0;
    while ((qa.size() + qb.size() + qc.size()) != 0 && i < bound) begin
      @(posedge CLK);
      i++;
    end
    if ((qa.size() + qb.size() + qc.size()) != 0) begin
      chk("valid_timeout_pending", qa.size() + qb.size() + qc.size(), 0);
      qa.delete(); qb.delete(); qc.delete();
    end
    repeat (3) @(posedge CLK);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  vec_t vt[8];

  initial begin
    vt[0] = '{md: 1'b1, t: 0, mn: 12,  cnt: 6, perm: 24'h088};
    vt[1] = '{md: 1'b0, t: 0, mn: 12,  cnt: 6, perm: 24'h088};
    vt[2] = '{md: 1'b0, t: 1, mn: 3,   cnt: 2, perm: 24'h011};
    vt[3] = '{md: 1'b1, t: 1, mn: 27,  cnt: 1, perm: 24'h088};
    vt[4] = '{md: 1'b0, t: 2, mn: 4,   cnt: 1, perm: 24'h00A};
    vt[5] = '{md: 1'b1, t: 2, mn: 8,   cnt: 1, perm: 24'h088};
    vt[6] = '{md: 1'b0, t: 3, mn: 381, cnt: 6, perm: 24'h088};
    vt[7] = '{md: 1'b1, t: 3, mn: 381, cnt: 6, perm: 24'h088};

    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_a_outputs", {mc_a, cnt_a, pm_a, v_a, b_a, w_a, j_a}, 0);
    chk("rst_b_outputs", {mc_b, cnt_b, pm_b, v_b, b_b, w_b, j_b}, 0);
    chk("rst_c_outputs", {mc_c, cnt_c, pm_c, v_c, b_c, w_c, j_c}, 0);
    @(negedge CLK);
    RST = 0;
    repeat (10) @(posedge CLK);
    #1;
    chk("a_no_start_after_reset", b_a, 0);

    // Table-driven N=3 searches
    for (int i = 0; i < 8; i++) begin
      go(0, vt[i].md, vt[i].t, vt[i].mn, vt[i].cnt, vt[i].perm, 24);
      wait_all(100);
    end

    // N=4 all-equal costs: unsaturated vs saturated match count
    go(1, 1'b0, 4, 20, 24, 24'h688, 120);
    go(2, 1'b0, 4, 20, 15, 24'h688, 120);
    wait_all(300);

    // Reset in the middle of an N=4 search
    go(1, 1'b0, 4, 20, 24, 24'h688, 120);
    repeat (9) @(posedge CLK);
    #2 RST = 1;
    #1;
    chk("b_midsearch_reset", {mc_b, cnt_b, pm_b, v_b, b_b, w_b, j_b}, 0);
    qb.delete();
    @(negedge CLK);
    @(negedge CLK);
    RST = 0;
    repeat (150) @(posedge CLK);
    #1;
    chk("b_idle_after_abort", b_b, 0);
    go(1, 1'b0, 0, 24, 24, 24'h688, 120);
    wait_all(300);

    // Start pulses and Mode toggles while busy and during DONE are ignored
    go(0, 1'b0, 2, 4, 1, 24'h00A, 24);
    for (int i = 0; i < 26; i++) begin
      @(negedge CLK);
      s_a = (i % 3 == 0) && (i != 25);
      m_a = ~m_a;
    end
    @(negedge CLK);
    s_a = 0;
    wait_all(50);
    repeat (40) @(posedge CLK);
    #1;
    chk("a_idle_after_ignored_starts", b_a, 0);
    chk("a_result_held", {mc_a, cnt_a, pm_a}, {10'd4, 4'd1, 9'h00A});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/jam_param.md
JAM_PARAM -- requirements
Module: jam_param

Interface
REQ-001 Parameter N, default 8: worker/job count, legal range 2..8.
REQ-002 Parameter CW, default 7: cost word width.
REQ-003 Parameter SW, default 10: accumulated-sum width, SHALL be >= CW+3.
REQ-004 Parameter MCW, default 4: MatchCount width.
REQ-005 Port CLK, input, 1: the single clock; all state updates on its rising edge.
REQ-006 Port RST, input, 1: reset, asynchronous and active-high.
REQ-007 Port Start, input, 1: begin a search; sampled only in IDLE.
REQ-008 Port Mode, input, 1: 0 = minimise cost, 1 = maximise; sampled with Start.
REQ-009 Port W, output, 3: worker index driven to the external cost ROM.
REQ-010 Port J, output, 3: job index driven to the external cost ROM.
REQ-011 Port Cost, input, CW: ROM data for (W,J), combinational, sampled on the edge ending the cycle in which W/J are driven.
REQ-012 Port MinCost, output, SW: best total found (min or max per Mode).
REQ-013 Port MatchCount, output, MCW: number of assignments achieving the best total.
REQ-014 Port BestPerm, output, 3*N: job of worker k at bits [3k+2:3k]; first best permutation in lexicographic order.
REQ-015 Port Valid, output, 1: one-cycle pulse, result ready.
REQ-016 Port Busy, output, 1: high in ACCUM and UPDATE.

Function
REQ-017 FSM states SHALL be IDLE, ACCUM, UPDATE, DONE.
REQ-018 IDLE: Start=1 at an edge -> latch Mode, load identity permutation (perm[k]=k), clear sum, k=0 -> ACCUM.
REQ-019 ACCUM: drive W=k, J=perm[k]; each edge adds Cost (zero-extended) into sum; after k=N-1 -> UPDATE.
REQ-020 UPDATE, first permutation: MinCost=sum, MatchCount=1, BestPerm=perm.
REQ-021 UPDATE, later permutations: strictly better sum (less for Mode 0, greater for Mode 1) -> replace MinCost/BestPerm, MatchCount=1; equal sum -> MatchCount+1 saturating at all-ones; worse -> no change.
REQ-022 UPDATE SHALL advance perm to its lexicographic successor in the same cycle; if perm was descending (last), -> DONE, else clear sum, k=0 -> ACCUM.
REQ-023 Each permutation SHALL take exactly N+1 cycles; Valid SHALL rise N!*(N+1) cycles after the edge sampling Start.
REQ-024 DONE: Valid=1 for exactly one cycle, then IDLE; MinCost/MatchCount/BestPerm hold until the next accepted Start.
REQ-025 Start while Busy or in DONE SHALL be ignored; Mode changes mid-search SHALL have no effect.
REQ-026 W and J SHALL be 0 outside ACCUM; upper index bits beyond N-1 never driven.
REQ-027 Sum arithmetic SHALL be unsigned, no overflow for N*(2^CW-1) given REQ-003.

Reset
REQ-028 RST=1 SHALL immediately force IDLE, and W, J, MinCost, MatchCount, BestPerm, Valid, Busy, sum and k to 0, including mid-search; the aborted search produces no Valid.
REQ-029 After RST deasserts, no search starts without a fresh Start.

Structure
REQ-030 Shared package jam_pkg SHALL hold the FSM state enum, index width constant (3) and max-N constant (8).
REQ-031 Successor logic SHALL be a sub-module jam_next_perm: combinational pivot search, swap, suffix reverse, plus an is_last flag.

Verification
REQ-032 N=8, Mode 0, cost[w][j]=0 if w==j else 10 -> MinCost=0, MatchCount=1, BestPerm=identity, Valid at cycle 362880 after Start.
REQ-033 N=4, MCW=5, all costs 5 -> MinCost=20, MatchCount=24; same with MCW=4 -> MatchCount=15 (saturated).
REQ-034 N=3, Mode 1, cost[w][j]=w*3+j -> MinCost=12, MatchCount=6, BestPerm=(0,1,2); Valid exactly 24 cycles after Start.
REQ-035 N=3, cost[w][j]=(w==j?9:1) -> MinCost=3, MatchCount=2, BestPerm=(1,2,0).
REQ-036 Assert RST at cycle 10 of an N=4 search -> all outputs 0 at once, no Valid; Start after release -> correct result.
REQ-037 Pulse Start repeatedly while Busy and during DONE -> single Valid, results and latency unchanged.
